// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single SRAM-like bus, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN swaps fixed data-first priority for alternating priority on contention.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              cancelled_q, cancelled_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic grant_s;
  logic pick_data_s;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q = 1 means data wins the next contended grant
  logic prio_q, prio_d;
  logic contend_s;

  // Winner selection with alternating priority under contention
  always_comb begin
    contend_s   = data_req & inst_req & ~inst_cancel;
    grant_s     = data_req | (inst_req & ~inst_cancel);
    pick_data_s = contend_s ? prio_q : data_req;
    if ((state_q == ST_IDLE) && contend_s) begin
      prio_d = ~pick_data_s;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  // Winner selection, data always ahead of fetch
  always_comb begin
    grant_s     = data_req | (inst_req & ~inst_cancel);
    pick_data_s = data_req;
  end
`endif

  // Next-state, command latch and handshake pulses
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cancelled_d  = cancelled_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cancelled_d = 1'b0;
        if (grant_s) begin
          state_d = ST_REQ;
          if (pick_data_s) begin
            owner_d = OWN_DATA;
            wr_d    = data_wr;
            size_d  = data_size;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end else begin
            owner_d = OWN_INST;
            wr_d    = 1'b0;
            size_d  = 2'd2;
            addr_d  = inst_addr;
            wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if ((owner_q == OWN_INST) && inst_cancel) begin
          cancelled_d = 1'b1;
        end else begin
          cancelled_d = cancelled_q;
        end
        // A cancelled fetch still sees addr_ok so the fetch stage can drop its request
        if (bus_addr_ok) begin
          state_d = ST_WAIT;
          if (owner_q == OWN_DATA) begin
            data_addr_ok = 1'b1;
          end else begin
            inst_addr_ok = 1'b1;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          state_d     = ST_IDLE;
          cancelled_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            data_data_ok = 1'b1;
          end else if (!(cancelled_q | inst_cancel)) begin
            inst_data_ok = 1'b1;
          end else begin
            inst_data_ok = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
          if ((owner_q == OWN_INST) && inst_cancel) begin
            cancelled_d = 1'b1;
          end else begin
            cancelled_d = cancelled_q;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cancelled_d = 1'b0;
      end
    endcase
  end

  // State and latched command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_INST;
      cancelled_q <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cancelled_q <= cancelled_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus_wr     = wr_q;
  assign bus_size   = size_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed test-plan scenarios plus random traffic
// checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inst_req, inst_cancel, data_req, data_wr;
  logic [AW-1:0] inst_addr, data_addr;
  logic [1:0]    data_size;
  logic [DW-1:0] data_wdata, bus_rdata;
  logic          bus_addr_ok, bus_data_ok;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata, bus_wdata;
  logic          bus_req, bus_wr, busy;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;

  always #10 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .busy(busy)
  );

  // Transaction-level model: one record for the transaction in flight
  logic          m_valid, m_acc, m_cancel, m_own_data, m_wr;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_grant, m_win;
  logic          m_busy, m_bus_req, m_inst_aok, m_data_aok, m_inst_dok, m_data_dok;
  logic          m_inst_aok_q, m_data_aok_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic          m_last_win_data, m_contend;
`endif

  always_comb begin
    m_grant = data_req || (inst_req && !inst_cancel);
`ifdef ARB_ROUND_ROBIN_EN
    m_contend = data_req && inst_req && !inst_cancel;
    m_win     = m_contend ? !m_last_win_data : data_req;
`else
    m_win     = data_req;
`endif
    m_busy     = m_valid;
    m_bus_req  = m_valid && !m_acc;
    m_inst_aok = m_bus_req && bus_addr_ok && !m_own_data;
    m_data_aok = m_bus_req && bus_addr_ok && m_own_data;
    m_inst_dok = m_valid && m_acc && bus_data_ok && !m_own_data && !(m_cancel || inst_cancel);
    m_data_dok = m_valid && m_acc && bus_data_ok && m_own_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_acc <= 1'b0; m_cancel <= 1'b0; m_own_data <= 1'b0;
      m_wr <= 1'b0; m_size <= 2'd0; m_addr <= '0; m_wdata <= '0;
      m_inst_aok_q <= 1'b0; m_data_aok_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_win_data <= 1'b0;
`endif
    end else begin
      m_inst_aok_q <= m_inst_aok;
      m_data_aok_q <= m_data_aok;
      if (!m_valid) begin
        if (m_grant) begin
          m_valid    <= 1'b1;
          m_acc      <= 1'b0;
          m_cancel   <= 1'b0;
          m_own_data <= m_win;
          m_addr     <= m_win ? data_addr : inst_addr;
          m_wr       <= m_win ? data_wr : 1'b0;
          m_size     <= m_win ? data_size : 2'd2;
          m_wdata    <= m_win ? data_wdata : 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
          if (m_contend) m_last_win_data <= m_win;
`endif
        end
      end else if (!m_acc) begin
        if (bus_addr_ok) m_acc <= 1'b1;
        if (inst_cancel && !m_own_data) m_cancel <= 1'b1;
      end else begin
        if (bus_data_ok) m_valid <= 1'b0;
        else if (inst_cancel && !m_own_data) m_cancel <= 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_bus_req", 32'(bus_req), 32'(m_bus_req));
        chk("m_inst_addr_ok", 32'(inst_addr_ok), 32'(m_inst_aok));
        chk("m_data_addr_ok", 32'(data_addr_ok), 32'(m_data_aok));
        chk("m_inst_data_ok", 32'(inst_data_ok), 32'(m_inst_dok));
        chk("m_data_data_ok", 32'(data_data_ok), 32'(m_data_dok));
        if (m_bus_req) begin
          chk("m_bus_addr", bus_addr, m_addr);
          chk("m_bus_wr", 32'(bus_wr), 32'(m_wr));
          chk("m_bus_size", 32'(bus_size), 32'(m_size));
          chk("m_bus_wdata", bus_wdata, m_wdata);
        end
        if (m_inst_dok) chk("m_inst_rdata", inst_rdata, bus_rdata);
        if (m_data_dok) chk("m_data_rdata", data_rdata, bus_rdata);
      end
    end
  endtask

  task automatic clr();
    inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
  endtask

  initial begin
    fork monitor(); join_none
    clr();
    inst_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    clr();
    #2 rst_n = 1'b1;

    // single fetch
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hbfc00000;
    @(negedge clk); #3;
    chk("fetch_bus_req", 32'(bus_req), 32'd1);
    chk("fetch_bus_addr", bus_addr, 32'hbfc00000);
    chk("fetch_bus_size", 32'(bus_size), 32'd2);
    chk("fetch_bus_wdata", bus_wdata, 32'd0);
    chk("fetch_aok_early", 32'(inst_addr_ok), 32'd0);
    chk("model_bus_req", 32'(m_bus_req), 32'd1);
    chk("model_bus_addr", m_addr, 32'hbfc00000);
    @(negedge clk); bus_addr_ok = 1'b1; #3;
    chk("fetch_aok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk); bus_addr_ok = 1'b0; inst_req = 1'b0; #3;
    chk("fetch_wait_bus_req", 32'(bus_req), 32'd0);
    chk("fetch_wait_busy", 32'(busy), 32'd1);
    @(negedge clk); #3;
    chk("fetch_dok_early", 32'(inst_data_ok), 32'd0);
    @(negedge clk); bus_data_ok = 1'b1; bus_rdata = 32'h24080001; #3;
    chk("fetch_dok", 32'(inst_data_ok), 32'd1);
    chk("fetch_rdata", inst_rdata, 32'h24080001);
    @(negedge clk); bus_data_ok = 1'b0; #3;
    chk("fetch_idle", 32'(busy), 32'd0);

    // contention on a zero-wait bus
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hbfc00004;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000010;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk); #3;
    chk("cont1_data_aok", 32'(data_addr_ok), 32'd1);
    chk("cont1_inst_aok", 32'(inst_addr_ok), 32'd0);
    chk("cont1_addr", bus_addr, 32'h80000010);
    chk("cont1_wr", 32'(bus_wr), 32'd0);
    @(negedge clk); data_req = 1'b0; #3;
    chk("cont1_data_dok", 32'(data_data_ok), 32'd1);
    @(negedge clk); #3;
    chk("cont1_gap", 32'(busy), 32'd0);
    @(negedge clk); #3;
    chk("cont1_inst_aok2", 32'(inst_addr_ok), 32'd1);
    chk("cont1_inst_addr", bus_addr, 32'hbfc00004);
    @(negedge clk); inst_req = 1'b0; #3;
    chk("cont1_inst_dok", 32'(inst_data_ok), 32'd1);
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hbfc00008; data_req = 1'b1; data_addr = 32'h80000020;
    @(negedge clk); #3;
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont2_inst_first", 32'(inst_addr_ok), 32'd1);
    chk("cont2_addr", bus_addr, 32'hbfc00008);
    @(negedge clk); inst_req = 1'b0;
`else
    chk("cont2_data_first", 32'(data_addr_ok), 32'd1);
    chk("cont2_addr", bus_addr, 32'h80000020);
    @(negedge clk); data_req = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk); #3;
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont2_loser", 32'(data_addr_ok), 32'd1);
    @(negedge clk); data_req = 1'b0;
`else
    chk("cont2_loser", 32'(inst_addr_ok), 32'd1);
    @(negedge clk); inst_req = 1'b0;
`endif
    @(negedge clk); #3;
    chk("cont2_idle", 32'(busy), 32'd0);

    // store (bus still zero-wait)
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h80000003; data_wdata = 32'h000000ab;
    @(negedge clk); #3;
    chk("st_wr", 32'(bus_wr), 32'd1);
    chk("st_size", 32'(bus_size), 32'd0);
    chk("st_wdata", bus_wdata, 32'h000000ab);
    chk("st_aok", 32'(data_addr_ok), 32'd1);
    @(negedge clk); data_req = 1'b0; data_wr = 1'b0; #3;
    chk("st_dok", 32'(data_data_ok), 32'd1);
    @(negedge clk); bus_data_ok = 1'b0; #3;
    chk("st_idle", 32'(busy), 32'd0);

    // cancel in WAIT, then next fetch proceeds normally
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hbfc00100;
    @(negedge clk); #3;
    chk("cw_aok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk); inst_req = 1'b0; inst_cancel = 1'b1; #3;
    chk("cw_busy", 32'(busy), 32'd1);
    @(negedge clk); inst_cancel = 1'b0; bus_data_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'hbfc00380; #3;
    chk("cw_suppressed", 32'(inst_data_ok), 32'd0);
    @(negedge clk); bus_data_ok = 1'b0; #3;
    chk("cw_idle", 32'(busy), 32'd0);
    @(negedge clk); #3;
    chk("cw_next_addr", bus_addr, 32'hbfc00380);
    chk("cw_next_aok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk); inst_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000abcd; #3;
    chk("cw_next_dok", 32'(inst_data_ok), 32'd1);
    chk("cw_next_rdata", inst_rdata, 32'h0000abcd);
    @(negedge clk); bus_data_ok = 1'b0;

    // cancel coincident with data_ok, then cancel during a data transaction
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hbfc00200;
    @(negedge clk); #3;
    chk("cc_aok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk); inst_req = 1'b0; inst_cancel = 1'b1; bus_data_ok = 1'b1; #3;
    chk("cc_suppressed", 32'(inst_data_ok), 32'd0);
    @(negedge clk); inst_cancel = 1'b0; bus_data_ok = 1'b0;
    @(negedge clk); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000040;
    @(negedge clk); #3;
    chk("cd_aok", 32'(data_addr_ok), 32'd1);
    @(negedge clk); data_req = 1'b0; inst_cancel = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5a5a5a5a; #3;
    chk("cd_dok", 32'(data_data_ok), 32'd1);
    chk("cd_rdata", data_rdata, 32'h5a5a5a5a);
    @(negedge clk); inst_cancel = 1'b0; bus_data_ok = 1'b0;

    // async reset while waiting for data
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hbfc00300;
    @(negedge clk);
    @(negedge clk); inst_req = 1'b0; bus_addr_ok = 1'b0; #3;
    chk("rw_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_busy_now", 32'(busy), 32'd0);
    chk("rw_bus_req_now", 32'(bus_req), 32'd0);
    @(negedge clk); #5 rst_n = 1'b1;
    @(negedge clk); bus_data_ok = 1'b1; #3;
    chk("rw_no_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rw_idle", 32'(busy), 32'd0);
    @(negedge clk); bus_data_ok = 1'b0;

    // random traffic, requesters hold until the model says accepted
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (inst_req && m_inst_aok_q) inst_req = 1'b0;
      if (data_req && m_data_aok_q) data_req = 1'b0;
      if (!inst_req && ($urandom_range(3) == 0)) begin
        inst_req  = 1'b1;
        inst_addr = $urandom;
      end
      if (!data_req && ($urandom_range(3) == 0)) begin
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(1));
        data_size  = 2'($urandom_range(2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      inst_cancel = ($urandom_range(7) == 0);
      bus_addr_ok = 1'($urandom_range(1));
      bus_data_ok = 1'($urandom_range(1));
      bus_rdata   = $urandom;
    end
    @(negedge clk); clr();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
